// File: rtl/msg_block_padder.sv
// Byte-serial Merkle-Damgard padder: passes message bytes through, then appends
// 0x80, zero fill and a 64-bit big-endian bit length so each message ends on a 64-byte block.
module msg_block_padder (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_block_end,
  output logic       out_msg_end,
  output logic       busy
);

  localparam int unsigned LEN_W       = 64;
  localparam int unsigned BLK_BYTES   = 64;
  localparam int unsigned CNT_W       = $clog2(BLK_BYTES);
  localparam int unsigned BYTE_CNT_W  = LEN_W - 3;
  localparam int unsigned LAST_POS    = BLK_BYTES - 1;
  localparam int unsigned PAD_END_POS = BLK_BYTES - (LEN_W / 8) - 1;

  typedef enum logic [1:0] {
    S_DATA  = 2'd0,
    S_PAD80 = 2'd1,
    S_ZERO  = 2'd2,
    S_LEN   = 2'd3
  } state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_blk_cnt;
  logic [BYTE_CNT_W-1:0]   r_byte_cnt;
  logic [7:0]              r_out_data;
  logic                    r_out_valid;
  logic                    r_out_block_end;
  logic                    r_out_msg_end;

  logic                    w_load;
  logic                    w_blk_last;
  logic                    w_pad_end;
  logic [LEN_W-1:0]        w_len;
  logic [2:0]              w_len_idx;
  logic [7:0]              w_len_byte;

  // Output register may load whenever it is empty or being drained.
  assign w_load     = !r_out_valid || out_ready;
  assign in_ready   = (r_state == S_DATA) && w_load;
  assign w_blk_last = (r_blk_cnt == CNT_W'(LAST_POS));
  assign w_pad_end  = (r_blk_cnt == CNT_W'(PAD_END_POS));

  // Length field sits at positions 56..63, so the low 3 bits of the position pick the byte, MSB first.
  assign w_len      = LEN_W'({r_byte_cnt, 3'b000});
  assign w_len_idx  = r_blk_cnt[2:0];
  assign w_len_byte = 8'(w_len >> {3'(3'd7 - w_len_idx), 3'b000});

  assign out_data      = r_out_data;
  assign out_valid     = r_out_valid;
  assign out_block_end = r_out_block_end;
  assign out_msg_end   = r_out_msg_end;
  assign busy          = (r_state != S_DATA);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= S_DATA;
      r_blk_cnt       <= '0;
      r_byte_cnt      <= '0;
      r_out_data      <= 8'h00;
      r_out_valid     <= 1'b0;
      r_out_block_end <= 1'b0;
      r_out_msg_end   <= 1'b0;
    end else if (w_load) begin
      case (r_state)
        S_DATA: begin
          if (in_valid) begin
            r_out_data      <= in_data;
            r_out_valid     <= 1'b1;
            r_out_block_end <= w_blk_last;
            r_out_msg_end   <= 1'b0;
            r_blk_cnt       <= r_blk_cnt + CNT_W'(1);
            r_byte_cnt      <= r_byte_cnt + BYTE_CNT_W'(1);
            if (in_last) begin
              r_state <= S_PAD80;
            end
          end else begin
            r_out_valid     <= 1'b0;
            r_out_block_end <= 1'b0;
            r_out_msg_end   <= 1'b0;
          end
        end
        S_PAD80: begin
          r_out_data      <= 8'h80;
          r_out_valid     <= 1'b1;
          r_out_block_end <= w_blk_last;
          r_out_msg_end   <= 1'b0;
          r_blk_cnt       <= r_blk_cnt + CNT_W'(1);
          r_state         <= w_pad_end ? S_LEN : S_ZERO;
        end
        S_ZERO: begin
          r_out_data      <= 8'h00;
          r_out_valid     <= 1'b1;
          r_out_block_end <= w_blk_last;
          r_out_msg_end   <= 1'b0;
          r_blk_cnt       <= r_blk_cnt + CNT_W'(1);
          if (w_pad_end) begin
            r_state <= S_LEN;
          end
        end
        S_LEN: begin
          r_out_data      <= w_len_byte;
          r_out_valid     <= 1'b1;
          r_out_block_end <= w_blk_last;
          r_out_msg_end   <= w_blk_last;
          r_blk_cnt       <= r_blk_cnt + CNT_W'(1);
          if (w_blk_last) begin
            r_byte_cnt <= '0;
            r_state    <= S_DATA;
          end
        end
        default: begin
          r_state <= S_DATA;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msg_block_padder.sv
// Bench for msg_block_padder: padded streams predicted from the padding rule with queues,
// checked on every output transfer and stall, plus literal spot checks of known streams.
module tb_msg_block_padder;

  typedef logic [7:0] bq_t [$];
  typedef struct packed {
    logic [7:0] d;
    logic       be;
    logic       me;
    logic       bz;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_block_end;
  logic       out_msg_end;
  logic       busy;

  int   n_checks;
  int   n_fail;
  int   rdy_mode;
  exp_t exp_q[$];
  bq_t  act_log;
  bq_t  s1_log;

  logic       prev_stall;
  logic [7:0] hold_d;
  logic       hold_be;
  logic       hold_me;

  msg_block_padder dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_block_end(out_block_end),
    .out_msg_end  (out_msg_end),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Padding rule: message, 0x80, zeros until length = 56 mod 64, then bit length big-endian.
  function automatic bq_t pad(input bq_t m);
    bq_t         r;
    logic [63:0] bits;
    r = m;
    r.push_back(8'h80);
    while ((r.size() % 64) != 56) r.push_back(8'h00);
    bits = 64'(m.size()) * 64'd8;
    for (int k = 7; k >= 0; k--) r.push_back(bits[k*8 +: 8]);
    return r;
  endfunction

  // Busy covers the cycles from the last message byte on the output up to the byte before the final one.
  task automatic expect_msg(input bq_t m);
    bq_t  p;
    exp_t e;
    p = pad(m);
    for (int j = 0; j < p.size(); j++) begin
      e.d  = p[j];
      e.be = ((j % 64) == 63);
      e.me = (j == p.size() - 1);
      e.bz = (j >= m.size() - 1) && (j <= p.size() - 2);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_msg(input bq_t m);
    int cnt;
    expect_msg(m);
    for (int i = 0; i < m.size(); i++) begin
      in_data  = m[i];
      in_valid = 1'b1;
      in_last  = (i == m.size() - 1);
      cnt      = 0;
      forever begin
        @(negedge clk);
        if (in_ready) break;
        cnt++;
        if (cnt > 2000) begin
          n_checks++;
          n_fail++;
          $display("FAIL accept_timeout: byte %0d never accepted", i);
          break;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 5000) begin
      @(posedge clk);
      c++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s drain_timeout: %0d bytes outstanding", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // out_ready driver: held high or toggled pseudo-randomly.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // Scoreboard: checks every transfer, stall stability and busy/in_ready during padding.
  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_data", 64'(out_data), 64'(hold_d));
        chk("stall_block_end", 64'(out_block_end), 64'(hold_be));
        chk("stall_msg_end", 64'(out_msg_end), 64'(hold_me));
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: data %0h with nothing expected", out_data);
        end else begin
          chk("busy", 64'(busy), 64'(exp_q[0].bz));
          if (exp_q[0].bz) chk("in_ready_padding", 64'(in_ready), 64'd0);
          if (out_ready) begin
            chk("out_data", 64'(out_data), 64'(exp_q[0].d));
            chk("out_block_end", 64'(out_block_end), 64'(exp_q[0].be));
            chk("out_msg_end", 64'(out_msg_end), 64'(exp_q[0].me));
            act_log.push_back(out_data);
            void'(exp_q.pop_front());
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      hold_d     = out_data;
      hold_be    = out_block_end;
      hold_me    = out_msg_end;
    end
  end

  initial begin
    bq_t abc, m55, m56, m64, mp;
    n_checks   = 0;
    n_fail     = 0;
    rdy_mode   = 0;
    prev_stall = 1'b0;
    reset      = 1'b0;
    in_data    = 8'h00;
    in_valid   = 1'b0;
    in_last    = 1'b0;

    abc = {};
    abc.push_back(8'h61); abc.push_back(8'h62); abc.push_back(8'h63);
    m55 = {}; for (int i = 0; i < 55; i++) m55.push_back(8'(i + 1));
    m56 = {}; for (int i = 0; i < 56; i++) m56.push_back(8'(i + 1));
    m64 = {}; for (int i = 0; i < 64; i++) m64.push_back(8'(i + 1));

    // Model pinned to hand-computed paddings.
    mp = pad(abc);
    chk("model_abc_size", 64'(mp.size()), 64'd64);
    chk("model_abc_80", 64'(mp[3]), 64'h80);
    chk("model_abc_len", 64'(mp[63]), 64'h18);
    mp = pad(m55);
    chk("model_55_80", 64'(mp[55]), 64'h80);
    chk("model_55_len", 64'({mp[62], mp[63]}), 64'h01B8);
    mp = pad(m56);
    chk("model_56_size", 64'(mp.size()), 64'd128);
    chk("model_56_len", 64'({mp[126], mp[127]}), 64'h01C0);

    // Reset state
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'h00);
    chk("rst_block_end", 64'(out_block_end), 64'd0);
    chk("rst_msg_end", 64'(out_msg_end), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // 1: "abc"
    act_log.delete();
    send_msg(abc);
    wait_drain("abc");
    chk("s1_size", 64'(act_log.size()), 64'd64);
    chk("s1_byte3", 64'(act_log[3]), 64'h80);
    chk("s1_byte63", 64'(act_log[63]), 64'h18);
    s1_log = act_log;

    // 2: 55 bytes, 0x80 directly before length
    act_log.delete();
    send_msg(m55);
    wait_drain("m55");
    chk("s2_size", 64'(act_log.size()), 64'd64);
    chk("s2_byte55", 64'(act_log[55]), 64'h80);
    chk("s2_len", 64'({act_log[62], act_log[63]}), 64'h01B8);

    // 3: 56 bytes, padding spills into a second block
    act_log.delete();
    send_msg(m56);
    wait_drain("m56");
    chk("s3_size", 64'(act_log.size()), 64'd128);
    chk("s3_byte56", 64'(act_log[56]), 64'h80);
    chk("s3_len", 64'({act_log[126], act_log[127]}), 64'h01C0);

    // 4: "abc" with random back-pressure
    rdy_mode = 1;
    act_log.delete();
    send_msg(abc);
    wait_drain("abc_stall");
    rdy_mode = 0;
    chk("s4_size", 64'(act_log.size()), 64'(s1_log.size()));
    for (int i = 0; i < act_log.size() && i < s1_log.size(); i++)
      chk("s4_stream", 64'(act_log[i]), 64'(s1_log[i]));

    // 5: reset during zero fill, then "abc"
    send_msg(abc);
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("s5_rst_valid", 64'(out_valid), 64'd0);
    chk("s5_rst_busy", 64'(busy), 64'd0);
    exp_q.delete();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    act_log.delete();
    send_msg(abc);
    wait_drain("abc_after_reset");
    chk("s5_size", 64'(act_log.size()), 64'(s1_log.size()));
    for (int i = 0; i < act_log.size() && i < s1_log.size(); i++)
      chk("s5_stream", 64'(act_log[i]), 64'(s1_log[i]));

    // 6: 64-byte message immediately followed by "abc"
    act_log.delete();
    send_msg(m64);
    send_msg(abc);
    wait_drain("m64_abc");
    chk("s6_size", 64'(act_log.size()), 64'd192);
    chk("s6_len", 64'({act_log[126], act_log[127]}), 64'h0200);
    chk("s6_second_start", 64'(act_log[128]), 64'h61);
    for (int i = 0; i < 64 && (128 + i) < act_log.size(); i++)
      chk("s6_second_stream", 64'(act_log[128 + i]), 64'(s1_log[i]));

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
